// File: rtl/data_memory_hs_pkg.sv
// Shared constants for the handshaked data memory: FSM state encodings and default sizing.
package data_memory_hs_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DEPTH   = 1024;
  localparam int DEF_LATENCY = 2;

  typedef enum logic [1:0] {
    MEMHS_IDLE = 2'd0,
    MEMHS_WAIT = 2'd1,
    MEMHS_RESP = 2'd2
  } memhs_state_e;

endpackage

// File: rtl/data_memory_hs_byte_merge.sv
// Combinational byte-lane merge: lanes with be set take the new data, the others keep the old word.
module data_memory_hs_byte_merge #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   old_word,
  input  logic [DATA_W-1:0]   new_word,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   merged
);

  always_comb begin
    merged = old_word;
    for (int i = 0; i < DATA_W / 8; i++) begin
      if (be[i]) merged[i*8 +: 8] = new_word[i*8 +: 8];
    end
  end

endmodule

// File: rtl/data_memory_hs.sv
// Word-addressed data memory with valid/ready request/response handshake and configurable latency.
// Optional commit trace and protocol warning: define DATA_MEMORY_HS_TRACE_EN.
module data_memory_hs
  import data_memory_hs_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  memhs_state_e        state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                accept, commit;
  logic                cur_write, cur_err;
  logic [ADDR_W-1:0]   cur_addr, cur_sel;
  logic [DATA_W-1:0]   cur_wdata, old_word, merged_word;
  logic [BE_W-1:0]     cur_be;
  logic [IDX_W-1:0]    cur_idx;

  assign req_ready  = reset & (state_q == MEMHS_IDLE);
  assign accept     = req_valid & req_ready;
  assign resp_valid = (state_q == MEMHS_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // With single-cycle latency the commit edge is the acceptance edge, so decode the live request then.
  always_comb begin
    if (state_q == MEMHS_IDLE) begin
      cur_write = req_write;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
      cur_be    = req_be;
    end else begin
      cur_write = write_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_be    = be_q;
    end
    cur_sel = cur_addr >> OFF_W;
    cur_idx = cur_sel[IDX_W-1:0];
    cur_err = (cur_addr[OFF_W-1:0] != '0) || (cur_sel >= ADDR_W'(DEPTH));
    old_word = mem[cur_idx];
  end

  data_memory_hs_byte_merge #(.DATA_W(DATA_W)) u_byte_merge (
    .old_word (old_word),
    .new_word (cur_wdata),
    .be       (cur_be),
    .merged   (merged_word)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      MEMHS_IDLE: begin
        if (accept) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = (LATENCY == 1) ? MEMHS_RESP : MEMHS_WAIT;
        end
      end
      MEMHS_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) state_d = MEMHS_RESP;
      end
      MEMHS_RESP: begin
        if (resp_ready) begin
          state_d = MEMHS_IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = MEMHS_IDLE;
    endcase
    commit = (state_d == MEMHS_RESP) && (state_q != MEMHS_RESP);
    if (commit) begin
      err_d   = cur_err;
      rdata_d = (!cur_write && !cur_err) ? old_word : '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= MEMHS_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately outside the reset domain; commit is already gated off while reset is low.
  always_ff @(posedge clock) begin
    if (commit && cur_write && !cur_err) mem[cur_idx] <= merged_word;
  end

`ifdef DATA_MEMORY_HS_TRACE_EN
  logic req_pending_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) req_pending_q <= 1'b0;
    else        req_pending_q <= req_valid & ~accept;
  end

  always_ff @(posedge clock) begin
    if (commit)
      $display("%0t data_memory_hs %s addr=%h be=%h data=%h err=%0d", $time,
               cur_write ? "W" : "R", cur_addr, cur_be,
               cur_write ? cur_wdata : old_word, cur_err);
    if (reset && state_q == MEMHS_IDLE && req_pending_q && !req_valid)
      $display("%0t data_memory_hs warning: req_valid dropped before acceptance", $time);
  end
`endif

endmodule

// File: tb/tb_data_memory_hs.sv
// Directed self-checking bench: LATENCY=2 instance for the main tests, LATENCY=1 instance for throughput.
module tb_data_memory_hs;

  logic        clock;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  logic        l1_req_valid, l1_req_ready, l1_req_write;
  logic [31:0] l1_req_addr, l1_req_wdata;
  logic [3:0]  l1_req_be;
  logic        l1_resp_valid, l1_resp_ready, l1_resp_err;
  logic [31:0] l1_resp_rdata;

  int n_checks = 0;
  int n_errors = 0;

  data_memory_hs #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .LATENCY(2)) u_dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  data_memory_hs #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .LATENCY(1)) u_dut_l1 (
    .clock(clock), .reset(reset),
    .req_valid(l1_req_valid), .req_ready(l1_req_ready), .req_write(l1_req_write),
    .req_addr(l1_req_addr), .req_wdata(l1_req_wdata), .req_be(l1_req_be),
    .resp_valid(l1_resp_valid), .resp_ready(l1_resp_ready),
    .resp_rdata(l1_resp_rdata), .resp_err(l1_resp_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Full transaction on the LATENCY=2 instance with resp_ready held high. Sampling is #1 after
  // each edge, so resp_valid is first seen just after acceptance edge+1, i.e. it is high at edge+2.
  task automatic apply_stimulus(input string tag, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be,
                                input logic [31:0] exp_rdata, input logic exp_err);
    check_output({tag, ".ready_pre"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_be = be;
    step();
    req_valid = 1'b0; req_write = ~wr; req_addr = addr ^ 32'h4; req_wdata = ~wdata; req_be = ~be;
    check_output({tag, ".wait_valid"}, 32'(resp_valid), 32'd0);
    check_output({tag, ".wait_ready"}, 32'(req_ready), 32'd0);
    step();
    check_output({tag, ".valid"}, 32'(resp_valid), 32'd1);
    check_output({tag, ".rdata"}, resp_rdata, exp_rdata);
    check_output({tag, ".err"}, 32'(resp_err), 32'(exp_err));
    step();
    check_output({tag, ".done_valid"}, 32'(resp_valid), 32'd0);
    check_output({tag, ".done_rdata"}, resp_rdata, 32'd0);
  endtask

  logic [31:0] l1_data [4];

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    resp_ready = 1'b1;
    l1_req_valid = 1'b0; l1_req_write = 1'b0; l1_req_addr = '0; l1_req_wdata = '0; l1_req_be = '0;
    l1_resp_ready = 1'b1;
    l1_data[0] = 32'hA5A5_0001; l1_data[1] = 32'h5A5A_0002;
    l1_data[2] = 32'h1234_5678; l1_data[3] = 32'h8765_4321;

    // Reset values
    step(); step();
    check_output("rst.req_ready", 32'(req_ready), 32'd0);
    check_output("rst.resp_valid", 32'(resp_valid), 32'd0);
    check_output("rst.resp_rdata", resp_rdata, 32'd0);
    check_output("rst.resp_err", 32'(resp_err), 32'd0);
    reset = 1'b1;
    #1;
    check_output("rst.req_ready_rel", 32'(req_ready), 32'd1);
    step();

    // Full write then read, lane-masked write, be=0 no-op
    apply_stimulus("t1.wr", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'd0, 1'b0);
    apply_stimulus("t1.rd", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);
    apply_stimulus("t2.wr", 1'b1, 32'h10, 32'h1122_3344, 4'b0101, 32'd0, 1'b0);
    apply_stimulus("t2.rd", 1'b0, 32'h10, 32'h0, 4'hF, 32'hDE22_BE44, 1'b0);
    apply_stimulus("t2.wr_be0", 1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, 32'd0, 1'b0);
    apply_stimulus("t2.rd_be0", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0);

    // Address errors: misaligned, index past DEPTH, upper bits set, suppressed write
    apply_stimulus("t3.misalign", 1'b0, 32'h13, 32'h0, 4'h0, 32'd0, 1'b1);
    apply_stimulus("t3.range", 1'b0, 32'h1000, 32'h0, 4'h0, 32'd0, 1'b1);
    apply_stimulus("t3.upper", 1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'd0, 1'b1);
    apply_stimulus("t3.wr_err", 1'b1, 32'h11, 32'h0, 4'hF, 32'd0, 1'b1);
    apply_stimulus("t3.rd_after", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0);

    // Back-pressure: response must hold while resp_ready is low
    resp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_be = 4'h0;
    step();
    req_valid = 1'b0; req_addr = 32'h0;
    step();
    for (int i = 0; i < 5; i++) begin
      check_output("t4.hold_valid", 32'(resp_valid), 32'd1);
      check_output("t4.hold_rdata", resp_rdata, 32'hDE22_BE44);
      check_output("t4.hold_err", 32'(resp_err), 32'd0);
      check_output("t4.hold_ready", 32'(req_ready), 32'd0);
      step();
    end
    resp_ready = 1'b1;
    step();
    check_output("t4.idle_valid", 32'(resp_valid), 32'd0);
    check_output("t4.idle_ready", 32'(req_ready), 32'd1);

    // Reset during WAIT must drop the uncommitted write
    apply_stimulus("t5.init", 1'b1, 32'h20, 32'h0102_0304, 4'hF, 32'd0, 1'b0);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFE_F00D; req_be = 4'hF;
    step();
    req_valid = 1'b0;
    reset = 1'b0;
    #1;
    check_output("t5.rst_valid", 32'(resp_valid), 32'd0);
    check_output("t5.rst_ready", 32'(req_ready), 32'd0);
    step();
    check_output("t5.rst_valid2", 32'(resp_valid), 32'd0);
    step();
    reset = 1'b1;
    step();
    apply_stimulus("t5.rd", 1'b0, 32'h20, 32'h0, 4'h0, 32'h0102_0304, 1'b0);

    // LATENCY=1: valid just after each acceptance edge, a new acceptance every second edge
    l1_req_valid = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 4; i++) begin
        l1_req_write = (pass == 0);
        l1_req_addr = 32'h40 + 32'(i * 4);
        l1_req_wdata = l1_data[i];
        l1_req_be = 4'hF;
        check_output("t6.ready", 32'(l1_req_ready), 32'd1);
        step();
        check_output("t6.valid", 32'(l1_resp_valid), 32'd1);
        check_output("t6.busy", 32'(l1_req_ready), 32'd0);
        check_output("t6.rdata", l1_resp_rdata, (pass == 0) ? 32'd0 : l1_data[i]);
        check_output("t6.err", 32'(l1_resp_err), 32'd0);
        step();
        check_output("t6.gap_valid", 32'(l1_resp_valid), 32'd0);
      end
    end
    l1_req_valid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
